// File: rtl/imem_prog_if.sv
// Fetch and load-port bundle between the CPU front end (or a boot loader) and imem_prog.
// The master drives requests and writes; the slave is the instruction memory.
interface imem_prog_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              rd_req;
    logic [31:0]       pc;
    logic              rd_valid;
    logic [DATA_W-1:0] instruction;
    logic              oob;
    logic              past_end;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   prog_len;

    modport master (
        output rd_req, pc, wr_en, wr_addr, wr_data,
        input  rd_valid, instruction, oob, past_end, prog_len
    );

    modport slave (
        input  rd_req, pc, wr_en, wr_addr, wr_data,
        output rd_valid, instruction, oob, past_end, prog_len
    );
endinterface

// File: rtl/imem_prog.sv
// Loadable instruction memory with a fixed-latency fetch pipeline, range flags
// and a program-length high-water mark.
module imem_prog #(
    parameter int                 DATA_W         = 32,
    parameter int                 DEPTH          = 64,
    parameter int                 READ_LAT       = 1,
    parameter logic [DATA_W-1:0]  NOP_WORD       = '0,
    parameter bit                 CLEAR_ON_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    imem_prog_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   prog_len_q;
    logic [ADDR_W:0]   wr_len;
    logic [ADDR_W-1:0] pc_idx;
    logic              oob_s1;
    logic              past_end_s1;

    logic [READ_LAT-1:0] vld_q;
    logic [READ_LAT-1:0] oob_q;
    logic [READ_LAT-1:0] pe_q;
    logic [DATA_W-1:0]   data_q [READ_LAT];

    // Full 32-bit compares so that large pc values never alias into the array.
    assign pc_idx      = bus.pc[ADDR_W-1:0];
    assign oob_s1      = (bus.pc >= 32'(DEPTH));
    assign past_end_s1 = (bus.pc >= 32'(prog_len_q));
    assign wr_len      = {1'b0, bus.wr_addr} + (ADDR_W+1)'(1);

    // Storage array; a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= NOP_WORD;
                end
            end
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // High-water mark; wr_addr tops out at DEPTH-1 so this saturates at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_len_q <= '0;
        end else if (bus.wr_en && (wr_len > prog_len_q)) begin
            prog_len_q <= wr_len;
        end
    end

    // Valid shifts every cycle; payload only advances behind a valid entry so
    // the output stage holds its last real result across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            oob_q <= '0;
            pe_q  <= '0;
            for (int s = 0; s < READ_LAT; s++) begin
                data_q[s] <= NOP_WORD;
            end
        end else begin
            vld_q[0] <= bus.rd_req;
            if (bus.rd_req) begin
                data_q[0] <= oob_s1 ? NOP_WORD : mem[pc_idx];
                oob_q[0]  <= oob_s1;
                pe_q[0]   <= past_end_s1;
            end
            for (int s = 1; s < READ_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                    oob_q[s]  <= oob_q[s-1];
                    pe_q[s]   <= pe_q[s-1];
                end
            end
        end
    end

    assign bus.rd_valid    = vld_q[READ_LAT-1];
    assign bus.instruction = data_q[READ_LAT-1];
    assign bus.oob         = oob_q[READ_LAT-1];
    assign bus.past_end    = pe_q[READ_LAT-1];
    assign bus.prog_len    = prog_len_q;
endmodule
